// File: rtl/cnn_layer_sched.sv
// cnn_layer_sched: top-level sequencer for the CNN inference pipeline.
// Starts each layer in order once a frame is buffered, waits for each done
// pulse, then hands the predicted digit to the UART transmitter.
// Optional feature macro: CNN_SCHED_TIMEOUT_EN (per-layer watchdog + ERR state).
module cnn_layer_sched #(
    parameter int NUM_LAYERS  = 5,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int CNT_W       = 21
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_rdy,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic [3:0]            result,
    input  logic                  tx_done,
    output logic [NUM_LAYERS-1:0] layer_strt,
    output logic                  trmt,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic                  err,
    output logic                  overrun,
    output logic [15:0]           frame_cnt
);

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    // The watchdog counter must be able to hold TIMEOUT_CYC.
    generate
        if (CNT_W < 1 || (64'd1 << CNT_W) <= 64'(TIMEOUT_CYC)) begin : g_bad_cnt_w
            $error("cnn_layer_sched: CNT_W too narrow for TIMEOUT_CYC");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT, S_TX, S_TXWAIT, S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  pend_q, pend_d;
    logic [NUM_LAYERS-1:0] layer_strt_q, layer_strt_d;
    logic                  trmt_q, trmt_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  overrun_q, overrun_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
`ifdef CNN_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
`endif

    // Next-state, strobe and bookkeeping logic; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        layer_strt_d = '0;
        trmt_d       = 1'b0;
        tx_data_d    = tx_data_q;
        overrun_d    = overrun_q;
        frame_cnt_d  = frame_cnt_q;
`ifdef CNN_SCHED_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        if (abort) begin
            // A frame_rdy in the same cycle is dropped along with everything else.
            state_d = S_IDLE;
            idx_d   = '0;
            pend_d  = 1'b0;
        end else begin
            // One frame may queue behind the running one; a second is lost.
            if (frame_rdy && state_q != S_IDLE) begin
                if (pend_q) overrun_d = 1'b1;
                else        pend_d    = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (frame_rdy || pend_q) begin
                        idx_d   = '0;
                        pend_d  = 1'b0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    layer_strt_d = NUM_LAYERS'(1) << idx_q;
`ifdef CNN_SCHED_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                    state_d      = S_WAIT;
                end
                S_WAIT: begin
                    // Only the active layer's done bit matters.
                    if (layer_done[idx_q]) begin
                        if (idx_q == LAST_IDX) begin
                            tx_data_d = {4'h0, result};
                            state_d   = S_TX;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = S_START;
                        end
                    end
`ifdef CNN_SCHED_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
                S_TX: begin
                    trmt_d  = 1'b1;
                    state_d = S_TXWAIT;
                end
                S_TXWAIT: begin
                    if (tx_done) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = S_IDLE;
                    end
                end
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            layer_strt_q <= '0;
            trmt_q       <= 1'b0;
            tx_data_q    <= 8'h00;
            overrun_q    <= 1'b0;
            frame_cnt_q  <= 16'd0;
`ifdef CNN_SCHED_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            layer_strt_q <= layer_strt_d;
            trmt_q       <= trmt_d;
            tx_data_q    <= tx_data_d;
            overrun_q    <= overrun_d;
            frame_cnt_q  <= frame_cnt_d;
`ifdef CNN_SCHED_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign layer_strt = layer_strt_q;
    assign trmt       = trmt_q;
    assign tx_data    = tx_data_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_ERR);
    assign overrun    = overrun_q;
    assign frame_cnt  = frame_cnt_q;
`ifdef CNN_SCHED_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Self-checking bench for cnn_layer_sched: a scoreboard of expected strobes
// (layer_strt / trmt+tx_data) filled as stimulus is driven, plus per-scenario
// timing and status checks.
module tb_cnn_layer_sched;

    localparam int NL = 5;
    localparam int TO = 100;
`ifdef CNN_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, frame_rdy = 1'b0, abort = 1'b0, tx_done = 1'b0;
    logic [NL-1:0] layer_done = '0;
    logic [3:0]    result = 4'h0;
    logic [NL-1:0] layer_strt;
    logic          trmt, busy, err, overrun;
    logic [7:0]    tx_data;
    logic [15:0]   frame_cnt;

    cnn_layer_sched #(.NUM_LAYERS(NL), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .frame_rdy(frame_rdy), .abort(abort),
        .layer_done(layer_done), .result(result), .tx_done(tx_done),
        .layer_strt(layer_strt), .trmt(trmt), .tx_data(tx_data), .busy(busy),
        .err(err), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0, exp_cnt = 0;

    typedef struct packed {
        logic          is_tx;
        logic [NL-1:0] strt;
        logic [7:0]    data;
    } ev_t;
    ev_t exp_q[$];

    function automatic ev_t mk_ev(input logic is_tx, input logic [NL-1:0] strt, input logic [7:0] data);
        ev_t e;
        e.is_tx = is_tx; e.strt = strt; e.data = data;
        return e;
    endfunction

    // Scoreboard: every strobe the DUT emits must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && (layer_strt != '0 || trmt)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected strt=%b trmt=%b (none expected)", layer_strt, trmt);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (trmt !== e.is_tx || layer_strt !== e.strt || (trmt && tx_data !== e.data)) begin
                    failures++;
                    $display("FAIL sb_strobe got trmt=%b strt=%b data=%h exp trmt=%b strt=%b data=%h",
                             trmt, layer_strt, tx_data, e.is_tx, e.strt, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Waits for layer_strt[k] at ref_cyc+2, answers with done 20 cycles later.
    // n_fr: extra frame_rdy pulses in the wait; stray: bogus layer_done bit.
    task automatic layer_step(input int k, input int ref_cyc, input logic [3:0] res,
                              input int n_fr, input int stray, output int m);
        int at = -1;
        for (int i = 0; i < 200; i++) begin
            if (layer_strt[k]) begin at = cyc; break; end
            tick();
        end
        checks++;
        if (at != ref_cyc + 2) begin
            failures++;
            $display("FAIL strt%0d_time got=%0d exp=%0d", k, at, ref_cyc + 2);
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (n_fr >= 2 && i == 9) begin
                checks++;
                if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_early got=%b exp=0", overrun); end
            end
            if (n_fr >= 2 && i == 12) begin
                checks++;
                if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
            end
            if (stray >= 0 && i == 10) begin
                checks++;
                if (layer_strt !== '0) begin failures++; $display("FAIL stray_done got=%b exp=0", layer_strt); end
            end
            frame_rdy  = (i == 5 && n_fr >= 1) || (i == 10 && n_fr >= 2);
            layer_done = (stray >= 0 && i == 8) ? (NL'(1) << stray) : '0;
        end
        layer_done = NL'(1) << k;
        result     = res;
        m          = cyc;
        if (k < NL - 1) exp_q.push_back(mk_ev(1'b0, NL'(1) << (k + 1), 8'h00));
        else            exp_q.push_back(mk_ev(1'b1, '0, {4'h0, res}));
        tick();
        layer_done = '0;
        result     = 4'h0;
    endtask

    // Checks tx_data and trmt timing, answers tx_done 50 cycles after trmt.
    task automatic tx_step(input int m, input logic [3:0] res, input bit pend_exp, output int t);
        int at = -1;
        bit moved = 0;
        checks++;
        if (tx_data !== {4'h0, res}) begin failures++; $display("FAIL tx_data_latch got=%h exp=%h", tx_data, {4'h0, res}); end
        for (int i = 0; i < 10; i++) begin
            if (trmt) begin at = cyc; break; end
            tick();
        end
        checks++;
        if (at != m + 2) begin failures++; $display("FAIL trmt_time got=%0d exp=%0d", at, m + 2); end
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (tx_data !== {4'h0, res}) moved = 1;
        end
        checks++;
        if (moved) begin failures++; $display("FAIL tx_data_hold got=changed exp=stable"); end
        tx_done = 1'b1;
        t = cyc;
        if (pend_exp) exp_q.push_back(mk_ev(1'b0, NL'(1), 8'h00));
        tick();
        tx_done = 1'b0;
        exp_cnt++;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_tx got=%b exp=0", busy); end
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    endtask

    task automatic start_frame(output int n0);
        frame_rdy = 1'b1;
        n0 = cyc;
        exp_q.push_back(mk_ev(1'b0, NL'(1), 8'h00));
        tick();
        frame_rdy = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_rise got=%b exp=1", busy); end
    endtask

    task automatic run_frame(input logic [3:0] res);
        int r, m, t;
        start_frame(r);
        for (int k = 0; k < NL; k++) begin layer_step(k, r, res, 0, -1, m); r = m; end
        tx_step(m, res, 1'b0, t);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({layer_strt, trmt, tx_data, busy, err, overrun, frame_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_vals got strt=%b trmt=%b data=%h busy=%b err=%b ovr=%b cnt=%0d exp=all0",
                     layer_strt, trmt, tx_data, busy, err, overrun, frame_cnt);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single_frame();
        run_frame(4'd7);
        repeat (3) tick();
    endtask

    task automatic test_pending();
        int r, m, t;
        start_frame(r);
        for (int k = 0; k < NL; k++) begin layer_step(k, r, 4'd2, (k == 2) ? 2 : 0, -1, m); r = m; end
        tx_step(m, 4'd2, 1'b1, t);
        r = t + 1;
        for (int k = 0; k < NL; k++) begin layer_step(k, r, 4'd9, 0, -1, m); r = m; end
        tx_step(m, 4'd9, 1'b0, t);
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
        repeat (3) tick();
    endtask

    task automatic test_stray_done();
        int r, m, t;
        start_frame(r);
        for (int k = 0; k < NL; k++) begin layer_step(k, r, 4'd0, 0, (k == 1) ? 3 : -1, m); r = m; end
        tx_step(m, 4'd0, 1'b0, t);
        repeat (3) tick();
    endtask

    task automatic test_abort_txwait();
        int r, m;
        bit seen = 0;
        start_frame(r);
        for (int k = 0; k < NL; k++) begin layer_step(k, r, 4'd5, 0, -1, m); r = m; end
        repeat (5) tick();
        abort = 1'b1; frame_rdy = 1'b1;
        tick();
        abort = 1'b0; frame_rdy = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL abort_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (layer_strt !== '0 || busy !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL abort_no_start got=started exp=idle"); end
    endtask

    task automatic test_timeout();
        int n0;
        start_frame(n0);
`ifdef CNN_SCHED_TIMEOUT_EN
        while (cyc < n0 + 101) tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_early got err=%b busy=%b exp err=0 busy=1", err, busy); end
        tick();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL to_fire got err=%b busy=%b exp err=1 busy=0", err, busy); end
`else
        repeat (150) tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL no_to got err=%b busy=%b exp err=0 busy=1", err, busy); end
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        run_frame(4'd1);
        checks++;
        if (err !== TO_EN) begin failures++; $display("FAIL err_sticky got=%b exp=%b", err, TO_EN); end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_wait();
        int r, m;
        start_frame(r);
        for (int k = 0; k < 3; k++) begin layer_step(k, r, 4'd6, 0, -1, m); r = m; end
        repeat (6) tick();
        checks++;
        if (busy !== 1'b1 || frame_cnt == 16'd0) begin failures++; $display("FAIL pre_reset got busy=%b cnt=%0d exp busy=1 cnt>0", busy, frame_cnt); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({layer_strt, trmt, tx_data, busy, err, overrun, frame_cnt} !== '0) begin
            failures++;
            $display("FAIL async_reset got strt=%b trmt=%b data=%h busy=%b err=%b ovr=%b cnt=%0d exp=all0",
                     layer_strt, trmt, tx_data, busy, err, overrun, frame_cnt);
        end
        exp_q.delete();
        exp_cnt = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_frame(4'd3);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_pending();
        test_stray_done();
        test_abort_txwait();
        test_timeout();
        test_reset_mid_wait();
        repeat (5) tick();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
